lc2k_alu_stage: RTL and testbench

Execute stage of the LC2K single-cycle CPU. It merges three pieces:
- the ALU operand-B select, choosing between the register-B value and the sign-extended offset;
- the 32-bit ALU, which does add, nor, branch compare and pass-through, plus the branch-equal flag;
- a clocked result register with a free-running cycle counter, which replaces the behavioural clock source with a synthesizable cycle/time base.

The combinational outputs feed data memory, the write-data mux and the PC mux. The registered outputs serve trace and debug.

---
 rtl/lc2k_alu_stage.sv | 68 ++++++
 tb/tb_lc2k_alu_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lc2k_alu_stage.sv
// LC2K execute stage: operand-B select, 32-bit ALU with branch-equal flag, trace register and cycle counter.
// Latency: alu_val_b/alu_result/beq_taken are combinational (0 cycles); alu_result_q/beq_taken_q/out_valid are 1 cycle.
// Backpressure: none; a new operation is accepted every cycle and invalid cycles simply hold the trace register.
module lc2k_alu_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     alu_val_a,
    input  logic [WIDTH-1:0]     reg_b_value,
    input  logic [WIDTH-1:0]     offset_extended,
    input  logic                 ctrl_alu_val_b,
    input  logic [1:0]           ctrl_operation,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     alu_val_b,
    output logic [WIDTH-1:0]     alu_result,
    output logic                 beq_taken,
    output logic [WIDTH-1:0]     alu_result_q,
    output logic                 beq_taken_q,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_CMP  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // Operand B: immediate offset for lw/sw/addressing, register B otherwise.
    always_comb begin
        alu_val_b = ctrl_alu_val_b ? offset_extended : reg_b_value;
    end

    // ALU and branch-equal flag; the flag is only meaningful for the compare op.
    always_comb begin
        alu_result = alu_val_a;
        beq_taken  = 1'b0;
        case (ctrl_operation)
            OP_ADD:  alu_result = alu_val_a + alu_val_b;
            OP_NOR:  alu_result = ~(alu_val_a | alu_val_b);
            OP_CMP: begin
                alu_result = alu_val_a - alu_val_b;
                beq_taken  = (alu_val_a == alu_val_b);
            end
            OP_PASS: alu_result = alu_val_a;
            default: alu_result = alu_val_a;
        endcase
    end

    // Trace register and free-running cycle counter; reset discards any pending capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_q <= '0;
            beq_taken_q  <= 1'b0;
            out_valid    <= 1'b0;
            cycle_count  <= '0;
        end else begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
            out_valid   <= in_valid;
            if (in_valid) begin
                alu_result_q <= alu_result;
                beq_taken_q  <= beq_taken;
            end
        end
    end

endmodule

// File: tb/tb_lc2k_alu_stage.sv
// Self-checking bench for lc2k_alu_stage: combinational outputs checked on drive, registered outputs via a scoreboard.
// Latency: expected registered state is queued at drive time and popped one edge later by the monitor.
// Backpressure: none; one operation driven per cycle.
module tb_lc2k_alu_stage;

    logic        clk;
    logic        reset;
    logic [31:0] alu_val_a;
    logic [31:0] reg_b_value;
    logic [31:0] offset_extended;
    logic        ctrl_alu_val_b;
    logic [1:0]  ctrl_operation;
    logic        in_valid;

    logic [31:0] alu_val_b;
    logic [31:0] alu_result;
    logic        beq_taken;
    logic [31:0] alu_result_q;
    logic        beq_taken_q;
    logic        out_valid;
    logic [31:0] cycle_count;

    // Second instance with a narrow counter so wrap-around is reachable quickly.
    logic [31:0] s_alu_val_b;
    logic [31:0] s_alu_result;
    logic        s_beq_taken;
    logic [31:0] s_alu_result_q;
    logic        s_beq_taken_q;
    logic        s_out_valid;
    logic [3:0]  s_cycle_count;

    int checks = 0;
    int errors = 0;
    bit done   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        beq;
        logic        vld;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];

    // Reference state of the registered stage.
    longint unsigned m_cnt   = 0;
    logic [31:0]     m_res   = 0;
    logic            m_beq   = 0;
    logic            m_vld   = 0;

    lc2k_alu_stage #(.WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_val_a       (alu_val_a),
        .reg_b_value     (reg_b_value),
        .offset_extended (offset_extended),
        .ctrl_alu_val_b  (ctrl_alu_val_b),
        .ctrl_operation  (ctrl_operation),
        .in_valid        (in_valid),
        .alu_val_b       (alu_val_b),
        .alu_result      (alu_result),
        .beq_taken       (beq_taken),
        .alu_result_q    (alu_result_q),
        .beq_taken_q     (beq_taken_q),
        .out_valid       (out_valid),
        .cycle_count     (cycle_count)
    );

    lc2k_alu_stage #(.WIDTH(32), .CNT_WIDTH(4)) dut_small (
        .clk             (clk),
        .reset           (reset),
        .alu_val_a       (alu_val_a),
        .reg_b_value     (reg_b_value),
        .offset_extended (offset_extended),
        .ctrl_alu_val_b  (ctrl_alu_val_b),
        .ctrl_operation  (ctrl_operation),
        .in_valid        (in_valid),
        .alu_val_b       (s_alu_val_b),
        .alu_result      (s_alu_result),
        .beq_taken       (s_beq_taken),
        .alu_result_q    (s_alu_result_q),
        .beq_taken_q     (s_beq_taken_q),
        .out_valid       (s_out_valid),
        .cycle_count     (s_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational result, queue the post-edge state, wait for negedge.
    task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] rb,
                        input logic [31:0] off, input logic sel, input logic [1:0] op,
                        input logic v);
        logic [31:0] b;
        logic [31:0] r;
        logic        eq;
        exp_t        e;
        reset           = rst;
        alu_val_a       = a;
        reg_b_value     = rb;
        offset_extended = off;
        ctrl_alu_val_b  = sel;
        ctrl_operation  = op;
        in_valid        = v;
        #1;
        b  = sel ? off : rb;
        eq = 1'b0;
        if (op == 2'd0)      r = a + b;
        else if (op == 2'd1) r = ~(a | b);
        else if (op == 2'd2) begin r = a - b; eq = (a == b); end
        else                 r = a;
        check("alu_val_b", {32'd0, alu_val_b}, {32'd0, b});
        check("alu_result", {32'd0, alu_result}, {32'd0, r});
        check("beq_taken", {63'd0, beq_taken}, {63'd0, eq});
        check("small_alu_result", {32'd0, s_alu_result}, {32'd0, r});

        if (rst) begin
            m_cnt = 0; m_res = 0; m_beq = 0; m_vld = 0;
        end else begin
            m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
            m_vld = v;
            if (v) begin m_res = r; m_beq = eq; end
        end
        e.res  = m_res;
        e.beq  = m_beq;
        e.vld  = m_vld;
        e.cnt  = m_cnt[31:0];
        e.cnt4 = 4'(m_cnt % 16);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after every rising edge compare registered outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("alu_result_q", {32'd0, alu_result_q}, {32'd0, e.res});
                check("beq_taken_q", {63'd0, beq_taken_q}, {63'd0, e.beq});
                check("out_valid", {63'd0, out_valid}, {63'd0, e.vld});
                check("cycle_count", {32'd0, cycle_count}, {32'd0, e.cnt});
                check("small_cycle_count", {60'd0, s_cycle_count}, {60'd0, e.cnt4});
            end else if (!done) begin
                check("scoreboard_underflow", 64'd1, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] rb;
        logic [1:0]  op;
        // Reset state.
        step(1, 32'h0, 32'h0, 32'h0, 0, 2'd0, 1);
        step(1, 32'h5, 32'h5, 32'h0, 0, 2'd2, 1);
        // Directed combinational cases, ten non-reset edges in total.
        step(0, 32'hFFFF_FFFF, 32'd2, 32'h0, 0, 2'd0, 1);        // add wrap -> 1
        step(0, 32'h0000_FF00, 32'h0, 32'hFFFF_FFF0, 1, 2'd1, 1); // nor -> 0xF
        step(0, 32'd5, 32'd5, 32'h0, 0, 2'd2, 1);                // equal -> beq
        step(0, 32'd5, 32'd6, 32'h0, 0, 2'd2, 1);                // -1, no beq
        step(0, 32'd5, 32'd5, 32'h0, 0, 2'd0, 1);                // add never flags beq
        step(0, 32'h1234, 32'hDEAD_BEEF, 32'h0, 0, 2'd3, 1);     // pass A
        step(0, 32'd3, 32'd4, 32'h0, 0, 2'd0, 1);                // capture 7
        step(0, 32'd9, 32'd9, 32'h0, 0, 2'd2, 0);                // hold 7
        step(0, 32'hAAAA, 32'h1, 32'h0, 0, 2'd1, 0);
        step(0, 32'h1, 32'h1, 32'h0, 0, 2'd3, 0);
        // Reset mid-run with a valid op pending: capture discarded.
        step(1, 32'd1, 32'd1, 32'h0, 0, 2'd2, 1);
        // Long run without reset: the 4-bit counter wraps.
        for (int i = 0; i < 20; i++)
            step(0, 32'(i), 32'(i * 3), 32'hFFFF_FFFF, 1'(i % 2), 2'(i % 4), 1'(i % 3 != 0));
        // Randomized traffic with occasional reset; compares often get equal operands.
        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 39) == 0), a, rb,
                 ($urandom_range(0, 1) == 0) ? a : $urandom,
                 1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)));
        end
        done = 1;
        check("scoreboard_drained", {32'd0, 32'(sb.size())}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
